// File: rtl/alu_muldiv_sequencer.sv
// alu_muldiv_sequencer
//   Multi-cycle 32x32 unsigned multiply and 32/32 unsigned divide, built by
//   time-sharing the execute-stage ripple ALU. One ALU add or subtract is
//   issued per cycle; the sequencer owns the ALU A/B/control inputs while busy.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op           request (accepted only when ready); op 0=mul, 1=div
//   opa, opb            multiplicand/dividend, multiplier/divisor
//   ready, done         idle indicator, one-cycle result-valid pulse
//   res_hi, res_lo      product[63:32]/remainder, product[31:0]/quotient
//   alu_a, alu_b        ALU operand drives
//   alu_control         ALU operation select
//   alu_out, alu_zero   ALU result and zero flag
module alu_muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0010;
    localparam logic [3:0] CTRL_ADD = 4'b0001;
    localparam logic [3:0] CTRL_SUB = 4'b0101;

    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} stateT;

    stateT            state, nextState;
    logic             opReg;
    logic [WIDTH-1:0] opaReg, opbReg;
    logic [WIDTH-1:0] hi, lo, m;      // mul: hi/lo/multiplicand, div: rem/q/divisor
    logic [4:0]       cnt;

    logic [WIDTH-1:0] rPrime;
    logic             bEff, cy, ok;
    logic [WIDTH-1:0] stepHi, stepLo;

    assign ready  = (state == IDLE);
    assign done   = (state == DONE);
    assign rPrime = {hi[WIDTH-2:0], lo[WIDTH-1]};

    // ALU drives depend only on current state and registers.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = CTRL_AND;
        case (state)
            LOAD: begin
                alu_a       = opbReg;
                alu_control = CTRL_OR;
            end
            ITER: begin
                if (!opReg) begin
                    alu_a       = hi;
                    alu_b       = lo[0] ? m : '0;
                    alu_control = CTRL_ADD;
                end else begin
                    alu_a       = rPrime;
                    alu_b       = m;
                    alu_control = CTRL_SUB;
                end
            end
            default: ;
        endcase
    end

    // The ALU has no carry-out; rebuild it from the operand and result MSBs.
    // For SUB the ALU internally adds ~B, so the effective B MSB is inverted.
    always_comb begin
        bEff = alu_control[2] ? ~alu_b[WIDTH-1] : alu_b[WIDTH-1];
        cy   = (alu_a[WIDTH-1] & bEff) | ((alu_a[WIDTH-1] ^ bEff) & ~alu_out[WIDTH-1]);
        ok   = hi[WIDTH-1] | cy;
        if (!opReg) begin
            stepHi = {cy, alu_out[WIDTH-1:1]};
            stepLo = {alu_out[0], lo[WIDTH-1:1]};
        end else begin
            stepHi = ok ? alu_out : rPrime;
            stepLo = {lo[WIDTH-2:0], ok};
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = LOAD;
            LOAD: nextState = (opReg && alu_zero) ? DONE : ITER;
            ITER: if (cnt == 5'd31) nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opReg  <= 1'b0;
            opaReg <= '0;
            opbReg <= '0;
            hi     <= '0;
            lo     <= '0;
            m      <= '0;
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (start) begin
                        opReg  <= op;
                        opaReg <= opa;
                        opbReg <= opb;
                    end
                end
                LOAD: begin
                    if (opReg && alu_zero) begin
                        res_lo <= '1;
                        res_hi <= opaReg;
                    end else begin
                        cnt <= '0;
                        hi  <= '0;
                        lo  <= opReg ? opaReg : opbReg;
                        m   <= opReg ? opbReg : opaReg;
                    end
                end
                ITER: begin
                    hi  <= stepHi;
                    lo  <= stepLo;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        res_hi <= stepHi;
                        res_lo <= stepLo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
module tb_alu_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [31:0] opa, opb;
    logic        ready, done;
    logic [31:0] res_hi, res_lo;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_out;
    logic        alu_zero;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [63:0] scoreboard[$];

    always #5 clk = ~clk;

    alu_muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
        .ready(ready), .done(done), .res_hi(res_hi), .res_lo(res_lo),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    // Behavioural 32-bit ALU the sequencer is paired with.
    always_comb begin
        case (alu_control)
            4'b0000: alu_out = alu_a & alu_b;
            4'b0010: alu_out = alu_a | alu_b;
            4'b0001: alu_out = alu_a + alu_b;
            4'b0101: alu_out = alu_a + ~alu_b + 32'd1;
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic opIn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (!opIn) begin
            p = {32'd0, a} * {32'd0, b};
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending op.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (scoreboard.size() == 0) begin
                checkVal("spuriousDone", 64'd1, 64'd0);
            end else begin
                checkVal("result", {res_hi, res_lo}, scoreboard.pop_front());
            end
        end
    end

    task automatic doOp(input logic opIn, input logic [31:0] a, input logic [31:0] b, input int pokeCyc);
        int cyc;
        int expLat;
        expLat = (opIn && b == 32'd0) ? 2 : 34;
        @(posedge clk); #1;
        checkVal("readyBeforeStart", {63'd0, ready}, 64'd1);
        start = 1'b1; op = opIn; opa = a; opb = b;
        scoreboard.push_back(model(opIn, a, b));
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        if (opIn && b == 32'd0) checkVal("loadCtrl", {60'd0, alu_control}, 64'h2);
        while (!done && cyc < 60) begin
            checkVal("readyBusy", {63'd0, ready}, 64'd0);
            if (cyc == pokeCyc) begin
                start = 1'b1; op = ~opIn; opa = $urandom; opb = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        checkVal("doneLatency", 64'(cyc), 64'(expLat));
        checkVal("readyAtDone", {63'd0, ready}, 64'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "Ready"}, {63'd0, ready}, 64'd1);
        checkVal({tag, "Done"}, {63'd0, done}, 64'd0);
        checkVal({tag, "Res"}, {res_hi, res_lo}, 64'd0);
        checkVal({tag, "AluAB"}, {alu_a, alu_b}, 64'd0);
        checkVal({tag, "AluCtrl"}, {60'd0, alu_control}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
        #2;
        checkResetOutputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        doOp(1'b0, 32'd7, 32'd6, -1);
        doOp(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
        doOp(1'b1, 32'd100, 32'd7, -1);
        doOp(1'b1, 32'hFFFFFFFF, 32'h80000001, -1);
        doOp(1'b1, 32'd5, 32'd0, -1);
        doOp(1'b0, 32'h12345678, 32'h9ABCDEF0, 10);   // start poked mid-ITER
        doOp(1'b1, 32'hDEADBEEF, 32'd3, 20);
        doOp(1'b0, 32'd0, 32'h55555555, -1);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom; rb = $urandom >> (i * 8);
            doOp(1'(i % 2), ra, rb, -1);
        end

        // Reset during cycle 12 of a multiply aborts it with no done.
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; opa = 32'd9; opb = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 checkResetOutputs("abort");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        doOp(1'b0, 32'd3, 32'd5, -1);

        @(posedge clk); #1;
        checkVal("pendingAtEnd", 64'(scoreboard.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
